// File: rtl/ebox_mem_req.sv
// EBOX initiator for the mbox memory port: one command in, timed req/read/write out.
// Optional read-pause-write support is enabled by defining EBOX_MEMREQ_RPW_EN.
module ebox_mem_req #(
  parameter int MEM_LATENCY = 1
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         cmdValid,
  output logic         cmdReady,
  input  logic         cmdRead,
  input  logic         cmdWrite,
  input  logic         cmdPSE,
  input  logic         cmdACRef,
  input  logic [13:35] cmdVMA,
  input  logic [0:35]  cmdData,
  output logic [13:35] vma,
  output logic         vmaACRef,
  output logic         req,
  output logic         read,
  output logic         write,
  output logic         PSE,
  output logic [0:35]  writeData,
  input  logic [0:35]  cacheDataRead,
  output logic         rspValid,
  output logic [0:35]  rspData,
  output logic         badCmd
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
`ifdef EBOX_MEMREQ_RPW_EN
    , PAUSE
`endif
  } state_e;

  localparam logic [3:0] LOAD = 4'(MEM_LATENCY - 1);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         isrd_q, isrd_d;
  logic         rpw_q, rpw_d;
  logic [13:35] vma_q, vma_d;
  logic         ac_q, ac_d;
  logic [0:35]  wd_q, wd_d;
  logic [0:35]  rsp_q, rsp_d;
  logic         bad_q, bad_d;
  logic         rdy_q, rdy_d;
  logic         req_q, req_d;
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic         rv_q, rv_d;
  logic         pse_q, pse_d;
  logic         paused_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    isrd_d  = isrd_q;
    rpw_d   = rpw_q;
    vma_d   = vma_q;
    ac_d    = ac_q;
    wd_d    = wd_q;
    rsp_d   = rsp_q;
    bad_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmdValid) begin
          if (cmdRead == cmdWrite) begin
            bad_d = 1'b1;
          end else begin
            vma_d   = cmdVMA;
            ac_d    = cmdACRef;
            wd_d    = cmdData;
            isrd_d  = cmdRead;
`ifdef EBOX_MEMREQ_RPW_EN
            rpw_d   = cmdRead & cmdPSE;
`else
            rpw_d   = 1'b0;
`endif
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d   = LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          if (isrd_q) rsp_d = cacheDataRead;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        rpw_d = 1'b0;
`ifdef EBOX_MEMREQ_RPW_EN
        state_d = rpw_q ? PAUSE : IDLE;
`else
        state_d = IDLE;
`endif
      end
`ifdef EBOX_MEMREQ_RPW_EN
      // Address and AC flag stay from the read; only data is new.
      PAUSE: begin
        if (cmdValid) begin
          if (cmdWrite && !cmdRead) begin
            wd_d    = cmdData;
            isrd_d  = 1'b0;
            state_d = REQ;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

`ifdef EBOX_MEMREQ_RPW_EN
  assign paused_d = (state_d == PAUSE);
`else
  assign paused_d = 1'b0;
`endif

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    req_d = (state_d == REQ);
    wr_d  = req_d & ~isrd_d;
    rd_d  = isrd_d & ((state_d == REQ) | (state_d == WAIT) |
                      (state_d == DONE));
    rv_d  = (state_d == DONE);
    pse_d = paused_d;
    rdy_d = (state_d == IDLE) | paused_d;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      isrd_q  <= 1'b0;
      rpw_q   <= 1'b0;
      vma_q   <= '0;
      ac_q    <= 1'b0;
      wd_q    <= '0;
      rsp_q   <= '0;
      bad_q   <= 1'b0;
      rdy_q   <= 1'b0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      rv_q    <= 1'b0;
      pse_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      isrd_q  <= isrd_d;
      rpw_q   <= rpw_d;
      vma_q   <= vma_d;
      ac_q    <= ac_d;
      wd_q    <= wd_d;
      rsp_q   <= rsp_d;
      bad_q   <= bad_d;
      rdy_q   <= rdy_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      rv_q    <= rv_d;
      pse_q   <= pse_d;
    end
  end

`ifndef EBOX_MEMREQ_RPW_EN
  logic unused_pse;
  assign unused_pse = cmdPSE;
`endif

  assign cmdReady  = rdy_q;
  assign vma       = vma_q;
  assign vmaACRef  = ac_q;
  assign req       = req_q;
  assign read      = rd_q;
  assign write     = wr_q;
  assign PSE       = pse_q;
  assign writeData = wd_q;
  assign rspValid  = rv_q;
  assign rspData   = rsp_q;
  assign badCmd    = bad_q;

endmodule
